// File: rtl/pio_in_pkg.sv
// ---------------------------------------------------------------------------
// pio_in_pkg
//   Shared definitions for the edge-capturing Avalon-MM input PIO.
//   Holds the slave register offsets, the edge-mode encodings and a small
//   helper that picks which detected edges are captured.
//   No ports; imported by avalon_pio_in_edge and pio_debounce_bit.
// ---------------------------------------------------------------------------
package pio_in_pkg;

  // Width of the Avalon data bus seen by the CPU.
  localparam int BUS_W = 32;

  typedef logic [1:0]       pio_addr_t;
  typedef logic [BUS_W-1:0] bus_word_t;

  // Word offsets inside the 4-word register map.
  localparam pio_addr_t ADDR_DATA    = 2'd0;
  localparam pio_addr_t ADDR_RSVD    = 2'd1;
  localparam pio_addr_t ADDR_IRQMASK = 2'd2;
  localparam pio_addr_t ADDR_EDGECAP = 2'd3;

  // Edge-mode encodings for the EDGE_MODE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Selects which edges set the capture register. Any unknown mode value
  // captures both directions so no event is silently dropped.
  function automatic bus_word_t select_edges(input int mode,
                                             input bus_word_t rise,
                                             input bus_word_t fall);
    bus_word_t result;
    case (mode)
      EDGE_RISE: result = rise;
      EDGE_FALL: result = fall;
      default:   result = rise | fall;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// ---------------------------------------------------------------------------
// pio_debounce_bit
//   One input bit of the PIO: a flop synchronizer followed by a
//   consecutive-stable-cycles debouncer. The debounced level only changes
//   after the synchronized input has disagreed with it for DEBOUNCE_CYCLES
//   clocks in a row; any return to the old level restarts the count.
//
//   Ports
//     clk_i     in  1  system clock
//     reset_i   in  1  synchronous active-high reset
//     pin_i     in  1  asynchronous board input
//     stable_o  out 1  debounced, synchronized level
// ---------------------------------------------------------------------------
module pio_debounce_bit
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic stable_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q;

  // Synchronizer chain: the pin enters at bit 0 and leaves from the top bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_bypass

      // Debounce disabled: the stable level simply follows the synchronizer
      // one clock later, which is the same timing a count of one would give.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          stable_q <= 1'b0;
        end else begin
          stable_q <= synced;
        end
      end

    end else begin : g_count

      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             stable_d;

      // The counter tracks how many clocks in a row the synchronized input
      // has disagreed with the accepted level. Agreement clears it; reaching
      // the limit accepts the new level and clears it as well.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (synced == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = synced;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

    end
  endgenerate

  assign stable_o = stable_q;

endmodule

// File: rtl/avalon_pio_in_edge.sv
// ---------------------------------------------------------------------------
// avalon_pio_in_edge
//   Parametrised Avalon-MM input PIO for push-buttons and switches.
//   Each input is synchronized and debounced, edges of the debounced level
//   are captured in a sticky write-1-to-clear register, and a masked OR of
//   the captured edges drives a level interrupt.
//
//   Register map (word offsets, reads zero-extended to 32 bits)
//     0  data     debounced input levels (writes ignored)
//     1  reserved reads 0 (writes ignored)
//     2  irqmask  read/write
//     3  edgecap  read, write 1 to clear a bit
//
//   Ports
//     clk        in  1      system clock
//     reset      in  1      synchronous active-high reset
//     address    in  2      word offset
//     chipselect in  1      slave select
//     write_n    in  1      active-low write strobe, qualified by chipselect
//     writedata  in  32     write data
//     readdata   out 32     registered read data, 1 clock latency
//     in_port    in  WIDTH  asynchronous board inputs
//     irq        out 1      level interrupt to the CPU
// ---------------------------------------------------------------------------
module avalon_pio_in_edge
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EDGE_MODE       = EDGE_FALL,
  parameter int CNT_W           = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stableDly_q;
  logic [WIDTH-1:0] irqMask_q;
  logic [WIDTH-1:0] irqMask_d;
  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [31:0]      readData_q;
  logic [31:0]      readData_d;

  logic             busWrite;
  logic [WIDTH-1:0] capClear;
  bus_word_t        riseWide;
  bus_word_t        fallWide;
  bus_word_t        edgeWide;
  logic [WIDTH-1:0] edgeHit;
  logic             unusedBits;

  // One synchronizer + debouncer per input bit.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk_i    (clk),
        .reset_i  (reset),
        .pin_i    (in_port[i]),
        .stable_o (stable[i])
      );
    end
  endgenerate

  // Edge detection compares the debounced level with its value one clock
  // earlier. The vectors are widened to the bus width so the shared
  // selection helper can be used for any WIDTH.
  always_comb begin
    riseWide             = '0;
    fallWide             = '0;
    riseWide[WIDTH-1:0]  = stable & ~stableDly_q;
    fallWide[WIDTH-1:0]  = ~stable & stableDly_q;
    edgeWide             = select_edges(EDGE_MODE, riseWide, fallWide);
    edgeHit              = edgeWide[WIDTH-1:0];
  end

  // Bus write decode. The clear mask is only non-zero during a write to
  // the edge-capture offset.
  always_comb begin
    busWrite  = chipselect & ~write_n;
    irqMask_d = irqMask_q;
    capClear  = '0;
    if (busWrite && (address == ADDR_IRQMASK)) begin
      irqMask_d = writedata[WIDTH-1:0];
    end
    if (busWrite && (address == ADDR_EDGECAP)) begin
      capClear = writedata[WIDTH-1:0];
    end
  end

  // Clear is applied before set, so an edge arriving in the same clock as
  // its own clear is still recorded.
  assign edgeCap_d = (edgeCap_q & ~capClear) | edgeHit;

  // Read mux. Reads have no side effects, so the result is registered every
  // clock regardless of chipselect.
  always_comb begin
    readData_d = '0;
    case (address)
      ADDR_DATA:    readData_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readData_d[WIDTH-1:0] = irqMask_q;
      ADDR_EDGECAP: readData_d[WIDTH-1:0] = edgeCap_q;
      default:      readData_d            = '0;
    endcase
  end

  // Register file and delayed level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      stableDly_q <= '0;
      irqMask_q   <= '0;
      edgeCap_q   <= '0;
      readData_q  <= '0;
    end else begin
      stableDly_q <= stable;
      irqMask_q   <= irqMask_d;
      edgeCap_q   <= edgeCap_d;
      readData_q  <= readData_d;
    end
  end

  assign readdata = readData_q;

  // Interrupt is a pure function of registered state, so it follows the
  // capture and mask registers with no added latency.
  assign irq = |(edgeCap_q & irqMask_q);

  // Bits of the bus above WIDTH carry no information for this block.
  assign unusedBits = &{1'b0, writedata, edgeWide};

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_in_edge
//   Directed bench for the edge-capturing input PIO with WIDTH=4,
//   SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and falling-edge capture. Hand-written
//   sequences cover reset, exact debounce latency, set-versus-clear
//   priority and reset during activity; a table of vectors covers glitch
//   rejection, capture, masking, clearing and ignored writes.
// ---------------------------------------------------------------------------
module tb_avalon_pio_in_edge;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checkCount;
  int failCount;

  typedef struct {
    string       name;
    logic [3:0]  inPort;
    logic [1:0]  addr;
    logic        doWrite;
    logic [31:0] wdata;
    int          cycles;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  avalon_pio_in_edge #(
    .WIDTH           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .EDGE_MODE       (1),
    .CNT_W           (18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [3:0] inPort,
                        input logic [1:0] addr, input logic doWrite,
                        input logic [31:0] wdata, input int cycles,
                        input logic [31:0] expRd, input logic expIrq);
    vec_t v;
    v.name    = name;
    v.inPort  = inPort;
    v.addr    = addr;
    v.doWrite = doWrite;
    v.wdata   = wdata;
    v.cycles  = cycles;
    v.expRd   = expRd;
    v.expIrq  = expIrq;
    vecs.push_back(v);
  endtask

  // Drive one vector: the write (if any) lasts only the first clock, the
  // inputs and address are held for the whole vector, then outputs are
  // compared.
  task automatic applyStimulus(input vec_t v);
    in_port    = v.inPort;
    address    = v.addr;
    writedata  = v.wdata;
    chipselect = v.doWrite;
    write_n    = ~v.doWrite;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int c = 1; c < v.cycles; c++) tick();
    checkOutput({v.name, "_rd"}, readdata, v.expRd);
    checkOutput({v.name, "_irq"}, {31'd0, irq}, {31'd0, v.expIrq});
  endtask

  // Single-clock bus write with the inputs left as they are.
  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;

    // Glitch rejection, capture, masking, clearing and ignored writes.
    addVec("glitch_low",      4'hD, 2'd0, 1'b0, 32'h0,         3, 32'hF, 1'b0);
    addVec("glitch_restore",  4'hF, 2'd0, 1'b0, 32'h0,         4, 32'hF, 1'b0);
    addVec("glitch_edgecap",  4'hF, 2'd3, 1'b0, 32'h0,         1, 32'h0, 1'b0);
    addVec("hold_pre",        4'hB, 2'd0, 1'b0, 32'h0,         6, 32'hF, 1'b0);
    addVec("hold_data",       4'hB, 2'd0, 1'b0, 32'h0,         1, 32'hB, 1'b0);
    addVec("hold_edgecap",    4'hB, 2'd3, 1'b0, 32'h0,         1, 32'h4, 1'b0);
    addVec("hold_rest",       4'hB, 2'd3, 1'b0, 32'h0,         2, 32'h4, 1'b0);
    addVec("mask_write",      4'hB, 2'd2, 1'b1, 32'hFFFF_FFF4, 1, 32'h0, 1'b1);
    addVec("mask_read",       4'hB, 2'd2, 1'b0, 32'h0,         1, 32'h4, 1'b1);
    addVec("clear_write",     4'hB, 2'd3, 1'b1, 32'h4,         1, 32'h4, 1'b0);
    addVec("clear_read",      4'hB, 2'd3, 1'b0, 32'h0,         1, 32'h0, 1'b0);
    addVec("wr_addr0_ign",    4'hB, 2'd0, 1'b1, 32'hFFFF_FFFF, 1, 32'hB, 1'b0);
    addVec("wr_addr1_ign",    4'hB, 2'd1, 1'b1, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
    addVec("mask_kept",       4'hB, 2'd2, 1'b0, 32'h0,         1, 32'h4, 1'b0);
    addVec("data_kept",       4'hB, 2'd0, 1'b0, 32'h0,         1, 32'hB, 1'b0);

    // Reset with all inputs high.
    reset      = 1'b1;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick();
    tick();
    checkOutput("reset_rd", readdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'h0);

    // Exact debounce latency: data appears on the 7th clock after release.
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkOutput($sformatf("startup_clk%0d", i), readdata,
                  (i == 7) ? 32'hF : 32'h0);
    end
    address = 2'd3;
    tick();
    checkOutput("startup_edgecap", readdata, 32'h0);
    checkOutput("startup_irq", {31'd0, irq}, 32'h0);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // New falling edge on bit 0 captured in the same clock as a clear of
    // bit 0: the edge must survive.
    in_port = 4'hA;
    address = 2'd3;
    for (int i = 1; i <= 6; i++) tick();
    checkOutput("setclr_pre", readdata, 32'h0);
    busWrite(2'd3, 32'h1);
    checkOutput("setclr_wrcycle", readdata, 32'h0);
    tick();
    checkOutput("setclr_kept", readdata, 32'h1);
    checkOutput("setclr_irq", {31'd0, irq}, 32'h0);

    // Unmask bit 0 so irq rises, start a debounce, then pulse reset.
    busWrite(2'd2, 32'h1);
    checkOutput("prerst_irq", {31'd0, irq}, 32'h1);
    in_port = 4'hF;
    address = 2'd0;
    for (int i = 1; i <= 3; i++) tick();
    checkOutput("prerst_irq_held", {31'd0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_irq", {31'd0, irq}, 32'h0);
    checkOutput("midrst_rd", readdata, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkOutput($sformatf("restart_clk%0d", i), readdata,
                  (i == 7) ? 32'hF : 32'h0);
    end
    address = 2'd2;
    tick();
    checkOutput("postrst_mask", readdata, 32'h0);
    address = 2'd3;
    tick();
    checkOutput("postrst_edgecap", readdata, 32'h0);
    checkOutput("postrst_irq", {31'd0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
